// File: rtl/config_bank_pkg.sv
// rtl/config_bank_pkg.sv - shared address map, command bits and types for the configuration bank
//
// Purpose: region base pages, index strides, CTRL bit positions, decoder region
//          and commit-state enums, and the matrix width helper.
// Ports:   none (package).
package config_bank_pkg;

  // Upper address byte selects the region; lower byte carries the index fields.
  localparam logic [7:0] PAGE_CTRL   = 8'h00;
  localparam logic [7:0] PAGE_MATRIX = 8'h01;
  localparam logic [7:0] PAGE_A      = 8'h02;
  localparam logic [7:0] PAGE_B      = 8'h03;
  localparam logic [7:0] PAGE_R2     = 8'h04;
  localparam logic [7:0] PAGE_W      = 8'h05;
  localparam logic [7:0] PAGE_SCALAR = 8'h06;
  localparam logic [7:0] PAGE_ROI    = 8'h07;

  localparam int MATRIX_CAM_STRIDE = 16;
  localparam int SCALE_STRIDE      = 32;
  localparam int W_STRIDE          = 16;
  localparam int ROI_CAM_STRIDE    = 4;
  localparam int MATRIX_ELEMS      = 9;
  localparam int N_WEIGHTS         = 3;

  localparam logic [7:0] CONF_OFFSET = 8'h00;
  localparam logic [7:0] COL_OFFSET  = 8'h10;
  localparam logic [7:0] ROW_OFFSET  = 8'h11;

  localparam int CTRL_ARM_BIT     = 0;
  localparam int CTRL_NOW_BIT     = 1;
  localparam int CTRL_CLR_ERR_BIT = 2;

  typedef enum logic [3:0] {
    REG_NONE, REG_CTRL, REG_MATRIX, REG_A, REG_B, REG_R2,
    REG_W, REG_CONF, REG_COL, REG_ROW, REG_ROI
  } region_t;

  typedef enum logic {ST_IDLE, ST_ARMED} commit_state_t;

  // Matrix elements carry 11 integer bits plus the fraction bits.
  function automatic int matrix_width(input int precision);
    return 11 + precision;
  endfunction

endpackage

// File: rtl/config_bank_if.sv
// rtl/config_bank_if.sv - write command interface carrying the bank clock
//
// Purpose: groups the command clock, address, data and valid strobe.
// Ports:   clk (in) - bank clock; addr[15:0], data[31:0], valid - write command.
// Modports: master drives commands; slave/writer receive them.
interface command_interface (input logic clk);
  logic [15:0] addr;
  logic [31:0] data;
  logic        valid;

  modport master (input clk, output addr, output data, output valid);
  modport slave  (input clk, input addr, input data, input valid);
  modport writer (input clk, input addr, input data, input valid);
endinterface

// File: rtl/config_addr_decode.sv
// rtl/config_addr_decode.sv - combinational address decoder for the configuration bank
//
// Purpose: maps a 16-bit address to a region, two index fields and a valid flag.
// Ports:   addr[15:0] (in); region (out); idx0[7:0] camera/scale/weight index (out);
//          idx1[7:0] element/zone/scale/field index (out); valid (out).
module config_addr_decode
  import config_bank_pkg::*;
#(
  parameter int N_CAMERAS = 2,
  parameter int N_SCALES  = 2,
  parameter int N_ZONES   = 16
) (
  input  logic [15:0] addr,
  output region_t     region,
  output logic [7:0]  idx0,
  output logic [7:0]  idx1,
  output logic        valid
);

  logic [31:0] off;
  assign off = {24'd0, addr[7:0]};

  always_comb begin
    region = REG_NONE;
    idx0   = '0;
    idx1   = '0;
    valid  = 1'b0;
    case (addr[15:8])
      PAGE_CTRL: begin
        if (addr[7:0] == 8'h00) begin
          region = REG_CTRL;
          valid  = 1'b1;
        end
      end
      PAGE_MATRIX: begin
        idx0 = 8'(off / MATRIX_CAM_STRIDE);
        idx1 = 8'(off % MATRIX_CAM_STRIDE);
        if ((off / MATRIX_CAM_STRIDE) < N_CAMERAS && (off % MATRIX_CAM_STRIDE) < MATRIX_ELEMS) begin
          region = REG_MATRIX;
          valid  = 1'b1;
        end
      end
      PAGE_A, PAGE_B: begin
        idx0 = 8'(off / SCALE_STRIDE);
        idx1 = 8'(off % SCALE_STRIDE);
        if ((off / SCALE_STRIDE) < N_SCALES && (off % SCALE_STRIDE) < N_ZONES) begin
          region = (addr[15:8] == PAGE_A) ? REG_A : REG_B;
          valid  = 1'b1;
        end
      end
      PAGE_R2: begin
        idx1 = addr[7:0];
        if (off < N_ZONES) begin
          region = REG_R2;
          valid  = 1'b1;
        end
      end
      PAGE_W: begin
        idx0 = 8'(off / W_STRIDE);
        idx1 = 8'(off % W_STRIDE);
        if ((off / W_STRIDE) < N_WEIGHTS && (off % W_STRIDE) < N_SCALES) begin
          region = REG_W;
          valid  = 1'b1;
        end
      end
      PAGE_SCALAR: begin
        valid = 1'b1;
        case (addr[7:0])
          CONF_OFFSET: region = REG_CONF;
          COL_OFFSET:  region = REG_COL;
          ROW_OFFSET:  region = REG_ROW;
          default:     valid  = 1'b0;
        endcase
      end
      PAGE_ROI: begin
        idx0 = 8'(off / ROI_CAM_STRIDE);
        idx1 = 8'(off % ROI_CAM_STRIDE);
        if ((off / ROI_CAM_STRIDE) < N_CAMERAS) begin
          region = REG_ROI;
          valid  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/config_bank.sv
// rtl/config_bank.sv - double-buffered DfDD configuration register bank
//
// Purpose: command writes land in a shadow copy; the shadow is copied atomically
//          into the active copy on an immediate or frame-deferred commit.
// Ports:   in (command_interface.writer) - clock plus write command;
//          rst_n_i - sync active-low reset; frame_start_i - frame boundary pulse;
//          rd_valid_i/rd_addr_i -> rd_valid_o/rd_data_o - one-cycle shadow readback;
//          a_o, b_o, r_squared_o, w0_o..w2_o, col/row_center_o, confidence_o,
//          bilinear_matrices_o - active parameters;
//          pre/post_bilinear_roi_boundaries_o - registered ROI top/bottom/left/right;
//          commit_pending_o, commit_done_o, err_unmapped_o - status.
module config_bank
  import config_bank_pkg::*;
#(
  parameter int N_CAMERAS = 2,
  parameter int N_SCALES  = 2,
  parameter int N_ZONES   = 16,
  parameter int PRECISION = 8,
  parameter logic [15:0] DEFAULT_A = 16'h3c00,
  parameter logic [15:0] DEFAULT_B = 16'h3c00,
  parameter logic [15:0] DEFAULT_W = 16'h3c00,
  parameter logic [15:0] DEFAULT_R_SQUARED = 16'h0000,
  parameter logic [15:0] DEFAULT_CONFIDENCE_MINIMUM = 16'h0000,
  parameter logic [15:0] COL_CENTER = 16'h00C8,
  parameter logic [15:0] ROW_CENTER = 16'h00C8,
  parameter logic [0:1][15:0] PRE_XFORM_ROI_DIMS  = '{16'd480, 16'd512},
  parameter logic [0:1][15:0] POST_XFORM_ROI_DIMS = '{16'd480, 16'd512},
  localparam int MATRIX_WIDTH = matrix_width(PRECISION),
  parameter logic [MATRIX_WIDTH-1:0] BILINEAR_1 = MATRIX_WIDTH'(1 << PRECISION)
) (
  command_interface.writer in,
  input  logic        rst_n_i,
  input  logic        frame_start_i,
  input  logic        rd_valid_i,
  input  logic [15:0] rd_addr_i,
  output logic        rd_valid_o,
  output logic [31:0] rd_data_o,
  output logic [15:0] a_o [N_SCALES][N_ZONES],
  output logic [15:0] b_o [N_SCALES][N_ZONES],
  output logic [15:0] r_squared_o [N_ZONES],
  output logic [15:0] w0_o [N_SCALES],
  output logic [15:0] w1_o [N_SCALES],
  output logic [15:0] w2_o [N_SCALES],
  output logic [15:0] col_center_o,
  output logic [15:0] row_center_o,
  output logic [15:0] confidence_o,
  output logic [MATRIX_WIDTH-1:0] bilinear_matrices_o [N_CAMERAS][3][3],
  output logic [15:0] pre_bilinear_roi_boundaries_o [N_CAMERAS][4],
  output logic [15:0] post_bilinear_roi_boundaries_o [N_CAMERAS][4],
  output logic        commit_pending_o,
  output logic        commit_done_o,
  output logic        err_unmapped_o
);

  // Only the low bits that some field can consume are captured.
  localparam int CMD_DW = (MATRIX_WIDTH > 16) ? MATRIX_WIDTH : 16;

  logic [15:0]       cmd_addr_q;
  logic [CMD_DW-1:0] cmd_data_q;
  logic              cmd_valid_q;

  region_t    wr_region, rd_region;
  logic [7:0] wr_idx0, wr_idx1, rd_idx0, rd_idx1;
  logic       wr_valid, rd_hit_valid;

  logic wr_hit, ctrl_wr, arm_req, now_req, clr_req, commit_fire;
  commit_state_t state_q, state_d;

  // Shadow copy; ROI corners are stored per camera as pre y, pre x, post y, post x.
  logic [15:0] sh_a [N_SCALES][N_ZONES];
  logic [15:0] sh_b [N_SCALES][N_ZONES];
  logic [15:0] sh_r2 [N_ZONES];
  logic [15:0] sh_w [N_WEIGHTS][N_SCALES];
  logic [15:0] sh_conf, sh_col, sh_row;
  logic [MATRIX_WIDTH-1:0] sh_mat [N_CAMERAS][3][3];
  logic [15:0] sh_roi [N_CAMERAS][4];
  logic [15:0] act_roi [N_CAMERAS][4];
  logic [31:0] rd_mux;

  config_addr_decode #(.N_CAMERAS(N_CAMERAS), .N_SCALES(N_SCALES), .N_ZONES(N_ZONES)) u_wr_dec (
    .addr(cmd_addr_q), .region(wr_region), .idx0(wr_idx0), .idx1(wr_idx1), .valid(wr_valid)
  );

  config_addr_decode #(.N_CAMERAS(N_CAMERAS), .N_SCALES(N_SCALES), .N_ZONES(N_ZONES)) u_rd_dec (
    .addr(rd_addr_i), .region(rd_region), .idx0(rd_idx0), .idx1(rd_idx1), .valid(rd_hit_valid)
  );

  assign wr_hit  = cmd_valid_q && wr_valid;
  assign ctrl_wr = wr_hit && (wr_region == REG_CTRL);
  assign arm_req = ctrl_wr && cmd_data_q[CTRL_ARM_BIT];
  assign now_req = ctrl_wr && cmd_data_q[CTRL_NOW_BIT];
  assign clr_req = ctrl_wr && cmd_data_q[CTRL_CLR_ERR_BIT];
  assign commit_pending_o = (state_q == ST_ARMED);

  always_ff @(posedge in.clk) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // An arm request wins over the commit it coincides with, so it survives
  // to the next frame boundary.
  always_comb begin
    state_d     = state_q;
    commit_fire = now_req;
    if (state_q == ST_ARMED && frame_start_i) begin
      commit_fire = 1'b1;
      state_d     = ST_IDLE;
    end
    if (now_req) state_d = ST_IDLE;
    if (arm_req) state_d = ST_ARMED;
  end

  // Command register and shadow copy.
  always_ff @(posedge in.clk) begin
    if (!rst_n_i) begin
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      cmd_valid_q <= 1'b0;
      for (int s = 0; s < N_SCALES; s++) begin
        for (int z = 0; z < N_ZONES; z++) begin
          sh_a[s][z] <= DEFAULT_A;
          sh_b[s][z] <= DEFAULT_B;
        end
        for (int k = 0; k < N_WEIGHTS; k++) sh_w[k][s] <= DEFAULT_W;
      end
      for (int z = 0; z < N_ZONES; z++) sh_r2[z] <= DEFAULT_R_SQUARED;
      for (int c = 0; c < N_CAMERAS; c++) begin
        for (int r = 0; r < 3; r++)
          for (int cc = 0; cc < 3; cc++)
            sh_mat[c][r][cc] <= (r == cc) ? BILINEAR_1 : '0;
        for (int f = 0; f < 4; f++) sh_roi[c][f] <= '0;
      end
      sh_conf <= DEFAULT_CONFIDENCE_MINIMUM;
      sh_col  <= COL_CENTER;
      sh_row  <= ROW_CENTER;
    end else begin
      cmd_addr_q  <= in.addr;
      cmd_data_q  <= in.data[CMD_DW-1:0];
      cmd_valid_q <= in.valid;
      for (int s = 0; s < N_SCALES; s++) begin
        for (int z = 0; z < N_ZONES; z++) begin
          if (wr_hit && wr_region == REG_A && wr_idx0 == 8'(s) && wr_idx1 == 8'(z))
            sh_a[s][z] <= cmd_data_q[15:0];
          if (wr_hit && wr_region == REG_B && wr_idx0 == 8'(s) && wr_idx1 == 8'(z))
            sh_b[s][z] <= cmd_data_q[15:0];
        end
        for (int k = 0; k < N_WEIGHTS; k++)
          if (wr_hit && wr_region == REG_W && wr_idx0 == 8'(k) && wr_idx1 == 8'(s))
            sh_w[k][s] <= cmd_data_q[15:0];
      end
      for (int z = 0; z < N_ZONES; z++)
        if (wr_hit && wr_region == REG_R2 && wr_idx1 == 8'(z)) sh_r2[z] <= cmd_data_q[15:0];
      for (int c = 0; c < N_CAMERAS; c++) begin
        for (int r = 0; r < 3; r++)
          for (int cc = 0; cc < 3; cc++)
            if (wr_hit && wr_region == REG_MATRIX && wr_idx0 == 8'(c) && wr_idx1 == 8'(3 * r + cc))
              sh_mat[c][r][cc] <= cmd_data_q[MATRIX_WIDTH-1:0];
        for (int f = 0; f < 4; f++)
          if (wr_hit && wr_region == REG_ROI && wr_idx0 == 8'(c) && wr_idx1 == 8'(f))
            sh_roi[c][f] <= cmd_data_q[15:0];
      end
      if (wr_hit && wr_region == REG_CONF) sh_conf <= cmd_data_q[15:0];
      if (wr_hit && wr_region == REG_COL)  sh_col  <= cmd_data_q[15:0];
      if (wr_hit && wr_region == REG_ROW)  sh_row  <= cmd_data_q[15:0];
    end
  end

  // Active copy; a commit on the same edge as a shadow write picks up the old shadow.
  always_ff @(posedge in.clk) begin
    if (!rst_n_i) begin
      for (int s = 0; s < N_SCALES; s++) begin
        for (int z = 0; z < N_ZONES; z++) begin
          a_o[s][z] <= DEFAULT_A;
          b_o[s][z] <= DEFAULT_B;
        end
        w0_o[s] <= DEFAULT_W;
        w1_o[s] <= DEFAULT_W;
        w2_o[s] <= DEFAULT_W;
      end
      for (int z = 0; z < N_ZONES; z++) r_squared_o[z] <= DEFAULT_R_SQUARED;
      for (int c = 0; c < N_CAMERAS; c++) begin
        for (int r = 0; r < 3; r++)
          for (int cc = 0; cc < 3; cc++)
            bilinear_matrices_o[c][r][cc] <= (r == cc) ? BILINEAR_1 : '0;
        for (int f = 0; f < 4; f++) act_roi[c][f] <= '0;
      end
      confidence_o  <= DEFAULT_CONFIDENCE_MINIMUM;
      col_center_o  <= COL_CENTER;
      row_center_o  <= ROW_CENTER;
      commit_done_o <= 1'b0;
    end else begin
      commit_done_o <= commit_fire;
      if (commit_fire) begin
        a_o                 <= sh_a;
        b_o                 <= sh_b;
        r_squared_o         <= sh_r2;
        w0_o                <= sh_w[0];
        w1_o                <= sh_w[1];
        w2_o                <= sh_w[2];
        bilinear_matrices_o <= sh_mat;
        act_roi             <= sh_roi;
        confidence_o        <= sh_conf;
        col_center_o        <= sh_col;
        row_center_o        <= sh_row;
      end
    end
  end

  // ROI boundaries trail the active corners by one edge; sums wrap at 16 bits.
  // Reset values are the boundaries of all-zero corners.
  always_ff @(posedge in.clk) begin
    for (int c = 0; c < N_CAMERAS; c++) begin
      if (!rst_n_i) begin
        pre_bilinear_roi_boundaries_o[c]  <= '{16'd0, PRE_XFORM_ROI_DIMS[0], 16'd0, PRE_XFORM_ROI_DIMS[1]};
        post_bilinear_roi_boundaries_o[c] <= '{16'd0, POST_XFORM_ROI_DIMS[0], 16'd0, POST_XFORM_ROI_DIMS[1]};
      end else begin
        pre_bilinear_roi_boundaries_o[c][0]  <= act_roi[c][0];
        pre_bilinear_roi_boundaries_o[c][1]  <= act_roi[c][0] + PRE_XFORM_ROI_DIMS[0];
        pre_bilinear_roi_boundaries_o[c][2]  <= act_roi[c][1];
        pre_bilinear_roi_boundaries_o[c][3]  <= act_roi[c][1] + PRE_XFORM_ROI_DIMS[1];
        post_bilinear_roi_boundaries_o[c][0] <= act_roi[c][2];
        post_bilinear_roi_boundaries_o[c][1] <= act_roi[c][2] + POST_XFORM_ROI_DIMS[0];
        post_bilinear_roi_boundaries_o[c][2] <= act_roi[c][3];
        post_bilinear_roi_boundaries_o[c][3] <= act_roi[c][3] + POST_XFORM_ROI_DIMS[1];
      end
    end
  end

  // Readback always returns the shadow; CTRL and unmapped addresses read as zero.
  always_comb begin
    rd_mux = '0;
    if (rd_hit_valid) begin
      case (rd_region)
        REG_MATRIX:
          for (int c = 0; c < N_CAMERAS; c++)
            for (int r = 0; r < 3; r++)
              for (int cc = 0; cc < 3; cc++)
                if (rd_idx0 == 8'(c) && rd_idx1 == 8'(3 * r + cc)) rd_mux = 32'(sh_mat[c][r][cc]);
        REG_A, REG_B:
          for (int s = 0; s < N_SCALES; s++)
            for (int z = 0; z < N_ZONES; z++)
              if (rd_idx0 == 8'(s) && rd_idx1 == 8'(z))
                rd_mux = {16'd0, (rd_region == REG_A) ? sh_a[s][z] : sh_b[s][z]};
        REG_R2:
          for (int z = 0; z < N_ZONES; z++)
            if (rd_idx1 == 8'(z)) rd_mux = {16'd0, sh_r2[z]};
        REG_W:
          for (int k = 0; k < N_WEIGHTS; k++)
            for (int s = 0; s < N_SCALES; s++)
              if (rd_idx0 == 8'(k) && rd_idx1 == 8'(s)) rd_mux = {16'd0, sh_w[k][s]};
        REG_ROI:
          for (int c = 0; c < N_CAMERAS; c++)
            for (int f = 0; f < 4; f++)
              if (rd_idx0 == 8'(c) && rd_idx1 == 8'(f)) rd_mux = {16'd0, sh_roi[c][f]};
        REG_CONF: rd_mux = {16'd0, sh_conf};
        REG_COL:  rd_mux = {16'd0, sh_col};
        REG_ROW:  rd_mux = {16'd0, sh_row};
        default:  rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge in.clk) begin
    if (!rst_n_i) begin
      rd_valid_o     <= 1'b0;
      rd_data_o      <= '0;
      err_unmapped_o <= 1'b0;
    end else begin
      rd_valid_o <= rd_valid_i;
      rd_data_o  <= rd_valid_i ? rd_mux : 32'd0;
      if (cmd_valid_q && !wr_valid) err_unmapped_o <= 1'b1;
      else if (clr_req)             err_unmapped_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_config_bank.sv
// tb/tb_config_bank.sv - self-checking bench for config_bank with a readback scoreboard
module tb_config_bank;
  localparam int NC = 2;
  localparam int NS = 2;
  localparam int NZ = 16;
  localparam int MW = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  command_interface cmd (.clk(clk));

  logic        rst_n_i, frame_start_i, rd_valid_i;
  logic [15:0] rd_addr_i;
  logic        rd_valid_o;
  logic [31:0] rd_data_o;
  logic [15:0] a_o [NS][NZ];
  logic [15:0] b_o [NS][NZ];
  logic [15:0] r_squared_o [NZ];
  logic [15:0] w0_o [NS];
  logic [15:0] w1_o [NS];
  logic [15:0] w2_o [NS];
  logic [15:0] col_center_o, row_center_o, confidence_o;
  logic [MW-1:0] bilinear_matrices_o [NC][3][3];
  logic [15:0] pre_roi [NC][4];
  logic [15:0] post_roi [NC][4];
  logic        commit_pending_o, commit_done_o, err_unmapped_o;

  config_bank dut (
    .in(cmd), .rst_n_i(rst_n_i), .frame_start_i(frame_start_i),
    .rd_valid_i(rd_valid_i), .rd_addr_i(rd_addr_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .a_o(a_o), .b_o(b_o), .r_squared_o(r_squared_o),
    .w0_o(w0_o), .w1_o(w1_o), .w2_o(w2_o),
    .col_center_o(col_center_o), .row_center_o(row_center_o), .confidence_o(confidence_o),
    .bilinear_matrices_o(bilinear_matrices_o),
    .pre_bilinear_roi_boundaries_o(pre_roi), .post_bilinear_roi_boundaries_o(post_roi),
    .commit_pending_o(commit_pending_o), .commit_done_o(commit_done_o),
    .err_unmapped_o(err_unmapped_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] sb_q [$];
  bit mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Readback scoreboard: expected data queued at request, compared on rd_valid_o.
  always @(negedge clk) begin
    if (mon_en && rd_valid_o) begin
      if (sb_q.size() == 0) check("rd_unexpected", 32'(rd_valid_o), 32'd0);
      else                  check("rd_data", rd_data_o, sb_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    cmd.addr  = a;
    cmd.data  = d;
    cmd.valid = 1'b1;
    @(posedge clk);
    #1;
    cmd.valid = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] e);
    rd_addr_i  = a;
    rd_valid_i = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    rd_valid_i = 1'b0;
    @(negedge clk);
    check("rd_valid_latency", 32'(rd_valid_o), 32'd1);
  endtask

  task automatic pulse_frame();
    frame_start_i = 1'b1;
    @(posedge clk);
    #1;
    frame_start_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp_roi [4];
    exp_roi = '{16'd0, 16'd480, 16'd0, 16'd512};
    rst_n_i = 1'b0; frame_start_i = 1'b0; rd_valid_i = 1'b0; rd_addr_i = '0;
    cmd.addr = '0; cmd.data = '0; cmd.valid = 1'b0;
    tick(3);
    rst_n_i = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Reset state
    check("rst_a", a_o[0][0], 32'h3c00);
    check("rst_b", b_o[1][15], 32'h3c00);
    check("rst_r2", r_squared_o[3], 32'h0);
    check("rst_w1", w1_o[1], 32'h3c00);
    check("rst_col", col_center_o, 32'h00c8);
    check("rst_row", row_center_o, 32'h00c8);
    check("rst_conf", confidence_o, 32'h0);
    check("rst_mat_diag", bilinear_matrices_o[1][2][2], 32'h100);
    check("rst_mat_off", bilinear_matrices_o[0][0][1], 32'h0);
    for (int i = 0; i < 4; i++) check("rst_pre_roi", pre_roi[0][i], exp_roi[i]);
    check("rst_post_roi", post_roi[1][1], 32'd480);
    check("rst_pending", commit_pending_o, 0);
    check("rst_done", commit_done_o, 0);
    check("rst_err", err_unmapped_o, 0);

    // Readback of defaults and unmapped reads
    rd(16'h0200, 32'h3c00);
    rd(16'h0104, 32'h100);
    rd(16'h0000, 32'h0);
    rd(16'h0611, 32'h00c8);
    rd(16'h0420, 32'h0);
    rd(16'h0522, 32'h0);
    check("rd_no_err", err_unmapped_o, 0);

    // Deferred commit
    wr(16'h0200, 32'h1234);
    wr(16'h0000, 32'h1);
    tick(2);
    check("defer_pending", commit_pending_o, 1);
    check("defer_hold", a_o[0][0], 32'h3c00);
    check("defer_no_done", commit_done_o, 0);
    rd(16'h0200, 32'h1234);
    check("defer_hold2", a_o[0][0], 32'h3c00);
    pulse_frame();
    check("defer_commit", a_o[0][0], 32'h1234);
    check("defer_done", commit_done_o, 1);
    check("defer_cleared", commit_pending_o, 0);
    check("defer_b_kept", b_o[0][0], 32'h3c00);
    tick(1);
    check("defer_done_once", commit_done_o, 0);

    // Immediate commit, matrix width masking, ROI wrap
    wr(16'h0700, 32'hfff0);
    wr(16'h0115, 32'hffffffff);
    wr(16'h0521, 32'h0abc);
    wr(16'h0000, 32'h2);
    check("now_before", bilinear_matrices_o[1][1][2], 32'h0);
    tick(1);
    check("now_mat", bilinear_matrices_o[1][1][2], 32'h7ffff);
    check("now_w2", w2_o[1], 32'h0abc);
    check("now_done", commit_done_o, 1);
    check("now_roi_lag", pre_roi[0][0], 32'h0);
    tick(1);
    check("roi_top", pre_roi[0][0], 32'hfff0);
    check("roi_bottom_wrap", pre_roi[0][1], 32'h01d0);
    check("roi_left", pre_roi[0][2], 32'h0);
    check("roi_right", pre_roi[0][3], 32'd512);
    check("roi_post_top", post_roi[0][0], 32'h0);
    check("now_done_once", commit_done_o, 0);
    rd(16'h0115, 32'h0007ffff);

    // Frame pulse coincident with a shadow update
    wr(16'h0000, 32'h1);
    wr(16'h0600, 32'h0042);
    pulse_frame();
    check("coinc_conf_old", confidence_o, 32'h0);
    check("coinc_done", commit_done_o, 1);
    check("coinc_cleared", commit_pending_o, 0);
    rd(16'h0600, 32'h0042);
    wr(16'h0000, 32'h1);
    tick(1);
    pulse_frame();
    check("coinc_conf_new", confidence_o, 32'h0042);

    // Unmapped writes
    wr(16'h0109, 32'h5555);
    wr(16'h0420, 32'h6666);
    check("err_set", err_unmapped_o, 1);
    tick(1);
    wr(16'h0000, 32'h2);
    tick(1);
    check("unmapped_mat", bilinear_matrices_o[0][0][0], 32'h100);
    check("unmapped_r2", r_squared_o[0], 32'h0);
    check("unmapped_a", a_o[0][0], 32'h1234);
    check("err_sticky", err_unmapped_o, 1);
    rd(16'h0109, 32'h0);
    rd(16'h0420, 32'h0);
    wr(16'h0000, 32'h4);
    tick(1);
    check("err_clear", err_unmapped_o, 0);

    // Reset while armed with a modified shadow
    wr(16'h0201, 32'h7777);
    wr(16'h0000, 32'h1);
    tick(1);
    check("rst_armed_pending", commit_pending_o, 1);
    rst_n_i = 1'b0;
    tick(1);
    rst_n_i = 1'b1;
    check("rst2_pending", commit_pending_o, 0);
    check("rst2_a", a_o[0][0], 32'h3c00);
    check("rst2_conf", confidence_o, 32'h0);
    check("rst2_mat", bilinear_matrices_o[1][1][2], 32'h0);
    check("rst2_w2", w2_o[1], 32'h3c00);
    check("rst2_roi_top", pre_roi[0][0], 32'h0);
    check("rst2_roi_bottom", pre_roi[0][1], 32'd480);
    pulse_frame();
    check("rst2_frame_no_done", commit_done_o, 0);
    check("rst2_frame_a", a_o[0][1], 32'h3c00);
    rd(16'h0201, 32'h3c00);

    tick(3);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
